// File: rtl/debounce_edge_if.sv
// Signal bundle between the bouncy source and the debounced consumer.
// raw_in travels toward the debouncer; the conditioned level, edge pulses
// and qualification status travel back.
interface debounce_edge_if;
  logic raw_in;
  logic clean_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  // Source side: drives the raw input, observes the conditioned outputs.
  modport master (
    output raw_in,
    input  clean_out, rise_pulse, fall_pulse, busy
  );

  // Debouncer side.
  modport slave (
    input  raw_in,
    output clean_out, rise_pulse, fall_pulse, busy
  );
endinterface

// File: rtl/debounce_edge.sv
// Debouncer for an asynchronous bouncy input: 2-flop synchroniser, a
// stability counter that must see STABLE_COUNT consecutive disagreeing
// samples before the clean level follows, and registered one-cycle
// rise/fall pulses at each accepted change.
module debounce_edge #(
  parameter int CNT_WIDTH    = 4,
  parameter int STABLE_COUNT = 10   // 2 .. 2**CNT_WIDTH
) (
  input  logic            clock,
  input  logic            clearb,
  debounce_edge_if.slave  bus
);

  // Terminal count; STABLE_COUNT-1 always fits in CNT_WIDTH bits.
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 sync1_q, sync2_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clean_q, clean_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // Qualify a candidate change: count while sync2 disagrees with the clean
  // level, drop the partial count the moment it agrees again, and commit
  // (with a pulse) on the STABLE_COUNT-th consecutive disagreement.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != clean_q) begin
      if (cnt_q == LAST) begin
        clean_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers; reset clears everything, so it never produces a pulse.
  always_ff @(posedge clock) begin
    if (!clearb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.clean_out  = clean_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = (cnt_q != '0);

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge. The reference keeps a per-edge log of raw_in and
// clearb and decides each output from run-length rules: the clean level
// flips at edge e only if the synchronised input (raw_in delayed two
// edges, zeroed by reset) disagreed with it at every one of the last
// STABLE_COUNT edges, none of which was a reset edge.
module tb_debounce_edge;
  localparam int SC   = 10;
  localparam int CW   = 4;
  localparam int MAXE = 4096;

  logic clock = 1'b0;
  logic clearb;
  debounce_edge_if bus ();

  debounce_edge #(.CNT_WIDTH(CW), .STABLE_COUNT(SC)) dut (
    .clock  (clock),
    .clearb (clearb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  bit r  [MAXE];
  bit rs [MAXE];
  int e = 0;
  bit clean_m = 1'b0;
  int errors = 0;
  int checks = 0;

  // Value sync1 holds after edge k.
  function automatic bit s1(int k);
    if (k < 0) return 1'b0;
    return rs[k] ? 1'b0 : r[k];
  endfunction

  // Value sync2 holds after edge k.
  function automatic bit s2(int k);
    if (k < 0) return 1'b0;
    return rs[k] ? 1'b0 : s1(k - 1);
  endfunction

  // True if every edge in (k-SC, k] was a non-reset edge whose sampled
  // synchronised input differed from level c.
  function automatic bit long_run(int k, bit c);
    if (k < SC) return 1'b0;
    for (int j = k - SC + 1; j <= k; j++) begin
      if (rs[j]) return 1'b0;
      if (s2(j - 1) == c) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  // One clock edge with the given inputs, then compare all outputs.
  task automatic step(bit v, bit c);
    bit flip, rise_m, fall_m, busy_m;
    bus.raw_in = v;
    clearb     = c;
    @(posedge clock);
    r[e]  = v;
    rs[e] = !c;
    rise_m = 1'b0;
    fall_m = 1'b0;
    busy_m = 1'b0;
    if (rs[e]) begin
      clean_m = 1'b0;
    end else begin
      flip = long_run(e, clean_m);
      if (flip) begin
        clean_m = ~clean_m;
        rise_m  = clean_m;
        fall_m  = ~clean_m;
      end else begin
        busy_m = (s2(e - 1) != clean_m);
      end
    end
    #1;
    chk("clean_out",  bus.clean_out,  clean_m);
    chk("rise_pulse", bus.rise_pulse, rise_m);
    chk("fall_pulse", bus.fall_pulse, fall_m);
    chk("busy",       bus.busy,       busy_m);
    chk("pulse_excl", bus.rise_pulse & bus.fall_pulse, 1'b0);
    e++;
  endtask

  task automatic hold(bit v, int n);
    for (int i = 0; i < n; i++) step(v, 1'b1);
  endtask

  initial begin
    int lat;
    bit done;
    bus.raw_in = 1'b0;
    clearb     = 1'b0;

    // Reset with raw_in toggling.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Clean rise; also measure latency in edges from the first sampling edge.
    hold(1'b0, 4);
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b1, 1'b1);
      lat++;
      if (bus.clean_out === 1'b1) done = 1'b1;
    end
    chk("rise_latency", (lat == SC + 2), 1'b1);
    hold(1'b1, 4);

    // Return to 0, then bounce rejection 5/2/8.
    hold(1'b0, 16);
    hold(1'b1, 5);
    hold(1'b0, 2);
    hold(1'b1, 8);
    hold(1'b0, 6);
    chk("bounce_clean", bus.clean_out, 1'b0);

    // Clean rise then clean fall.
    hold(1'b1, 16);
    hold(1'b0, 16);
    chk("fall_done", bus.clean_out, 1'b0);

    // Reset mid fall-qualification, release with raw_in=1.
    hold(1'b1, 16);
    hold(1'b0, 6);
    step(1'b0, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    hold(1'b1, 14);
    chk("post_rst_clean", bus.clean_out, 1'b1);

    // Threshold boundary: 9 disagreeing edges rejected, 10 accepted.
    hold(1'b0, 16);
    hold(1'b1, SC - 1);
    hold(1'b0, 6);
    chk("thr9_clean", bus.clean_out, 1'b0);
    hold(1'b1, SC);
    hold(1'b0, 2);
    chk("thr10_clean", bus.clean_out, 1'b1);
    hold(1'b0, 16);

    // Random runs with occasional resets.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0)
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'(($urandom)), 1'b0);
      else
        hold(1'($urandom), int'($urandom_range(1, 14)));
    end
    hold(1'b0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", e);
    $fatal(1);
  end
endmodule
